// File: rtl/tm_fir_mac_seq.sv
// tm_fir_mac_seq: time-multiplexed FIR sequencer and MAC.
// It drives an external SRL tap delay line and consumes the tap it selects.
// Each accepted sample is shifted into the delay line in the accept cycle.
// The block then sweeps the M taps, adding one product per cycle into the
// accumulator. It presents one output per input sample on a valid/ready handshake.
//
// Optional build macro: OUT_ROUND_SAT_EN
//   undefined : y = acc[SHIFT+OWL-1:SHIFT] (truncating slice, wraps)
//   defined   : y = sat_OWL((acc + 2^(SHIFT-1)) >>> SHIFT) (round half up, saturate)
//
// Ports:
//   CLK, RSTN            clock (rising edge), async active-low reset
//   in_valid/in_ready    input sample handshake, in_data = sample (signed WL)
//   dl_en/dl_din         delay-line shift enable / shift-in data (combinational)
//   dl_sel/dl_out        delay-line tap select / tap data (dl_out combinational from dl_sel)
//   coef_we/addr/data    coefficient write port, honoured only while idle
//   out_valid/out_ready  output handshake, y = filtered output (OWL)
module tm_fir_mac_seq #(
    parameter int unsigned M     = 16,
    parameter int unsigned WL    = 14,
    parameter int unsigned CWL   = 16,
    parameter int unsigned LML   = 4,
    parameter int unsigned OWL   = 16,
    parameter int unsigned SHIFT = 14
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WL-1:0]    in_data,
    output logic             dl_en,
    output logic [WL-1:0]    dl_din,
    output logic [LML-1:0]   dl_sel,
    input  logic [WL-1:0]    dl_out,
    input  logic             coef_we,
    input  logic [LML-1:0]   coef_addr,
    input  logic [CWL-1:0]   coef_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OWL-1:0]   y
);

    localparam int unsigned PWL    = WL + CWL;
    localparam int unsigned AWL    = WL + CWL + LML;
    localparam logic [LML-1:0] K_LAST = LML'(M - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [LML-1:0]         k_q, k_d;
    logic signed [AWL-1:0]  acc_q, acc_d;
    logic signed [PWL-1:0]  prod_q, prod_d;
    logic                   prod_v_q, prod_v_d;
    logic [OWL-1:0]         y_q, y_d;
    logic                   out_valid_q, out_valid_d;
    logic [CWL-1:0]         coef_q [M];
    logic                   coef_wr;

    logic signed [PWL-1:0]  mult;
    logic signed [AWL-1:0]  acc_fin;
    logic [OWL-1:0]         y_fmt;

    // Signed tap x coefficient product for the tap currently selected.
    assign mult    = PWL'($signed(dl_out)) * PWL'($signed(coef_q[k_q]));
    // Accumulator plus the pipelined product, sign-extended.
    assign acc_fin = acc_q + AWL'(prod_q);

`ifdef OUT_ROUND_SAT_EN
    localparam int unsigned RSH = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [AWL-1:0] RND = (SHIFT == 0) ? AWL'(0) : (AWL'(1) << RSH);

    logic signed [AWL-1:0]  rounded;
    logic signed [AWL-1:0]  scaled;
    logic [AWL-OWL:0]       hi;

    // Round half up, scale, then clamp when the bits above the output sign disagree.
    always_comb begin
        rounded = acc_fin + RND;
        scaled  = rounded >>> SHIFT;
        hi      = scaled[AWL-1:OWL-1];
        if ((&hi) || !(|hi)) begin
            y_fmt = scaled[OWL-1:0];
        end else if (scaled[AWL-1]) begin
            y_fmt = {1'b1, {(OWL-1){1'b0}}};
        end else begin
            y_fmt = {1'b0, {(OWL-1){1'b1}}};
        end
    end
`else
    // Plain truncating window of the accumulator.
    assign y_fmt = acc_fin[SHIFT+OWL-1:SHIFT];
`endif

    // Next-state, datapath and combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_v_d    = prod_v_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        coef_wr     = 1'b0;
        in_ready    = 1'b0;
        dl_en       = 1'b0;
        dl_sel      = '0;
        dl_din      = in_data;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                dl_en    = in_valid;
                coef_wr  = coef_we && (32'(coef_addr) < M);
                if (in_valid) begin
                    acc_d    = '0;
                    k_d      = '0;
                    prod_v_d = 1'b0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                dl_sel   = k_q;
                prod_d   = mult;
                prod_v_d = 1'b1;
                if (prod_v_q) begin
                    acc_d = acc_fin;
                end
                k_d = k_q + LML'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last product is still in prod_q; fold it in and publish.
                acc_d       = acc_fin;
                y_d         = y_fmt;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Coefficient store; a write coinciding with an accept is visible to that run.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(M); i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule
